jive_reg_file_p: RTL and testbench



---
 rtl/jive_pkg.sv | 29 ++
 rtl/jive_reg_file_p_if.sv | 54 +++++
 rtl/jive_rf_mem.sv | 40 ++++
 rtl/jive_reg_file_p.sv | 214 +++++++++++++++++++++
 tb/tb_jive_reg_file_p.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jive_pkg
// Description : Shared definitions for the jive_reg_file_p register file:
//               operand-select encodings, clear/idle FSM states and the
//               highest slice index belonging to x0.
// Revision    : 1.0 - initial release
// ============================================================================
package jive_pkg;

  // Operand source select for rs1/rs2.
  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,
    SEL_ALT   = 2'b01,
    SEL_CSR   = 2'b10,
    SEL_CONST = 2'b11
  } rs_sel_e;

  // Post-reset clear sequencer states.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } rf_state_e;

  // Slices 0 and 1 form x0, which is hard-wired to zero.
  localparam int X0_LAST_IDX = 1;

endpackage
`default_nettype wire

// File: rtl/jive_reg_file_p_if.sv
`default_nettype none
// ============================================================================
// Module      : jive_reg_file_p_if
// Description : Bus bundle between the decode/microcode sequencer (master)
//               and the register file (slave).
//   Control   : init_req -> / rdy <-
//   Read      : rs_rden, rs1/rs2_sel, rs1/rs2_idx, msw_sel, rdata_a,
//               csr_rdata, immed, zimmed -> / rs1_data, rs2_data <-
//   Writeback : wb_ena, wb_idx, wb_wren, wb_pc, wb_data -> / bad_pc <-
// Revision    : 1.0 - initial release
// ============================================================================
interface jive_reg_file_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int ZIMM_W = 6
) ();

  logic                init_req;
  logic                rdy;
  logic                msw_sel;
  logic                rs_rden;
  logic [1:0]          rs1_sel;
  logic [1:0]          rs2_sel;
  logic [ADDR_W-1:0]   rs1_idx;
  logic [ADDR_W-1:0]   rs2_idx;
  logic [DATA_W-1:0]   rdata_a;
  logic [DATA_W-1:0]   csr_rdata;
  logic [2*DATA_W-1:0] immed;
  logic [ZIMM_W-1:0]   zimmed;
  logic [DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]   rs2_data;
  logic                wb_ena;
  logic [ADDR_W-1:0]   wb_idx;
  logic                wb_wren;
  logic                wb_pc;
  logic [DATA_W-1:0]   wb_data;
  logic                bad_pc;

  modport master (
    output init_req, msw_sel, rs_rden, rs1_sel, rs2_sel, rs1_idx, rs2_idx,
           rdata_a, csr_rdata, immed, zimmed,
           wb_ena, wb_idx, wb_wren, wb_pc, wb_data,
    input  rdy, rs1_data, rs2_data, bad_pc
  );

  modport slave (
    input  init_req, msw_sel, rs_rden, rs1_sel, rs2_sel, rs1_idx, rs2_idx,
           rdata_a, csr_rdata, immed, zimmed,
           wb_ena, wb_idx, wb_wren, wb_pc, wb_data,
    output rdy, rs1_data, rs2_data, bad_pc
  );

endinterface
`default_nettype wire

// File: rtl/jive_rf_mem.sv
`default_nettype none
// ============================================================================
// Module      : jive_rf_mem
// Description : 1W/1R synchronous RAM, DATA_W x 2**ADDR_W. Registered read;
//               a read and write to the same address in one cycle returns
//               the old contents.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address (sampled on the rising edge)
//   rdata_o  out  read data, valid the cycle after raddr_i is sampled
// Revision    : 1.0 - initial release
// ============================================================================
module jive_rf_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [ADDR_W-1:0] waddr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic [ADDR_W-1:0] raddr_i,
  output      logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/jive_reg_file_p.sv
`default_nettype none
// ============================================================================
// Module      : jive_reg_file_p
// Description : Parametrised self-initialising dual-read register file.
//               Even slice = LSW, odd slice = MSW. A clear sequencer zeroes
//               every slice after reset or init_req; operands come out two
//               cycles after the read is presented.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  slave modport of jive_reg_file_p_if (read, writeback, control)
// Optional build macro: JIVE_RF_BYPASS_EN enables write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module jive_reg_file_p
  import jive_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int ZIMM_W = 6
) (
  input wire logic         clk,
  input wire logic         rst,
  jive_reg_file_p_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(2**ADDR_W - 1);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              rdy_q;
  logic              bad_pc_q;
  logic              idle;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.init_req) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rdy_q     <= 1'b0;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign idle = (state_q == ST_IDLE);

  // ---------------------------------------------------------- writeback
  logic              lsw_pc;
  logic              fault;
  logic              wr_eff;
  logic [DATA_W-1:0] wr_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign lsw_pc  = bus.wb_pc & ~bus.wb_idx[0];
  assign fault   = bus.wb_wren & lsw_pc & bus.wb_data[1];
  // A pending bad_pc swallows the next write: it is the faulting PC's MSW.
  assign wr_eff  = idle & bus.wb_ena & bus.wb_wren &
                   (bus.wb_idx > ADDR_W'(X0_LAST_IDX)) & ~fault & ~bad_pc_q;
  assign wr_data = {bus.wb_data[DATA_W-1:1], bus.wb_data[0] & ~lsw_pc};

  // The clear sequencer owns the write port outside IDLE.
  assign mem_we    = ~idle | wr_eff;
  assign mem_waddr = idle ? bus.wb_idx : clr_cnt_q;
  assign mem_wdata = idle ? wr_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bad_pc_q <= 1'b0;
    end else if (idle && bus.wb_ena) begin
      bad_pc_q <= fault;
    end
  end

  // ------------------------------------------------------------ memories
  logic [DATA_W-1:0] mem1_rdata, mem2_rdata;
  logic [DATA_W-1:0] mem1_data, mem2_data;

  jive_rf_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_rs1 (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (bus.rs1_idx),
    .rdata_o (mem1_rdata)
  );

  jive_rf_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_rs2 (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (bus.rs2_idx),
    .rdata_o (mem2_rdata)
  );

  // ------------------------------------------------------- p0 -> p1 regs
  logic    rden_p1_q;
  logic    msw_p1_q;
  rs_sel_e sel1_p1_q, sel2_p1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rden_p1_q <= 1'b0;
      msw_p1_q  <= 1'b0;
      sel1_p1_q <= SEL_REG;
      sel2_p1_q <= SEL_REG;
    end else begin
      rden_p1_q <= idle & bus.rs_rden;
      msw_p1_q  <= bus.msw_sel;
      sel1_p1_q <= rs_sel_e'(bus.rs1_sel);
      sel2_p1_q <= rs_sel_e'(bus.rs2_sel);
    end
  end

  // -------------------------------------------------------------- bypass
`ifdef JIVE_RF_BYPASS_EN
  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_idx_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] raddr1_p1_q, raddr2_p1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_vld_q    <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      raddr1_p1_q <= '0;
      raddr2_p1_q <= '0;
    end else begin
      wr_vld_q    <= wr_eff;
      wr_idx_q    <= bus.wb_idx;
      wr_data_q   <= wr_data;
      raddr1_p1_q <= bus.rs1_idx;
      raddr2_p1_q <= bus.rs2_idx;
    end
  end

  // The write registered from p0 is checked first so that a live p1 write
  // to the same slice overrides it (latest write wins). wr_eff never targets
  // x0, so x0 is never forwarded.
  always_comb begin
    mem1_data = mem1_rdata;
    mem2_data = mem2_rdata;
    if (wr_vld_q && (wr_idx_q == raddr1_p1_q)) mem1_data = wr_data_q;
    if (wr_vld_q && (wr_idx_q == raddr2_p1_q)) mem2_data = wr_data_q;
    if (wr_eff && (bus.wb_idx == raddr1_p1_q)) mem1_data = wr_data;
    if (wr_eff && (bus.wb_idx == raddr2_p1_q)) mem2_data = wr_data;
  end
`else
  assign mem1_data = mem1_rdata;
  assign mem2_data = mem2_rdata;
`endif

  // ------------------------------------------------------- p2 operand mux
  logic [DATA_W-1:0] rs1_d, rs2_d, rs1_q, rs2_q;

  always_comb begin
    rs1_d = mem1_data;
    case (sel1_p1_q)
      SEL_REG:   rs1_d = mem1_data;
      SEL_ALT:   rs1_d = bus.rdata_a;
      SEL_CSR:   rs1_d = mem1_data | bus.csr_rdata;
      SEL_CONST: rs1_d = msw_p1_q ?
                         {bus.zimmed[ZIMM_W-1], {(DATA_W-1){1'b0}}} :
                         {{(DATA_W-ZIMM_W+1){1'b0}}, bus.zimmed[ZIMM_W-2:0]};
    endcase
  end

  always_comb begin
    rs2_d = mem2_data;
    case (sel2_p1_q)
      SEL_REG:   rs2_d = mem2_data;
      SEL_ALT:   rs2_d = msw_p1_q ? bus.immed[2*DATA_W-1:DATA_W] :
                                    bus.immed[DATA_W-1:0];
      SEL_CSR:   rs2_d = mem2_data | bus.csr_rdata;
      SEL_CONST: rs2_d = msw_p1_q ? '0 : DATA_W'(4);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (rden_p1_q && idle) begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign bus.rdy      = rdy_q;
  assign bus.rs1_data = rs1_q;
  assign bus.rs2_data = rs2_q;
  assign bus.bad_pc   = bad_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_jive_reg_file_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_jive_reg_file_p
// Description : Self-checking bench for jive_reg_file_p: reset/clear timing,
//               table-driven operand-mux vectors, writeback forwarding, PC
//               fault handling and the init_req restart.
//               Expected forwarding results follow JIVE_RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jive_reg_file_p;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int ZIMM_W = 6;

`ifdef JIVE_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jive_reg_file_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZIMM_W(ZIMM_W)) bus ();

  jive_reg_file_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZIMM_W(ZIMM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rden;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [5:0]  i1;
    logic [5:0]  i2;
    logic        msw;
    logic [15:0] ra;
    logic [15:0] csr;
    logic [31:0] imm;
    logic [5:0]  z;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock (to the next falling edge) and drop one-shot controls.
  task automatic step();
    @(negedge clk);
    bus.init_req = 1'b0;
    bus.rs_rden  = 1'b0;
    bus.wb_ena   = 1'b0;
    bus.wb_wren  = 1'b0;
    bus.wb_pc    = 1'b0;
  endtask

  task automatic set_wb(input logic [5:0] idx, input logic [15:0] d, input logic pc);
    bus.wb_ena  = 1'b1;
    bus.wb_wren = 1'b1;
    bus.wb_idx  = idx;
    bus.wb_data = d;
    bus.wb_pc   = pc;
  endtask

  task automatic set_rd(input logic [5:0] i1, input logic [5:0] i2,
                        input logic [1:0] s1, input logic [1:0] s2);
    bus.rs_rden = 1'b1;
    bus.rs1_idx = i1;
    bus.rs2_idx = i2;
    bus.rs1_sel = s1;
    bus.rs2_sel = s2;
  endtask

  task automatic read_chk(input string name, input logic [5:0] i1, input logic [5:0] i2,
                          input logic [15:0] e1, input logic [15:0] e2);
    set_rd(i1, i2, 2'b00, 2'b00);
    step();
    step();
    check({name, "_rs1"}, bus.rs1_data, e1);
    check({name, "_rs2"}, bus.rs2_data, e2);
  endtask

  task automatic wait_rdy(input string name, input int exp_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.rdy && n < 300);
    check(name, n, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.init_req = 0; bus.msw_sel = 0; bus.rs_rden = 0;
    bus.rs1_sel = 0; bus.rs2_sel = 0; bus.rs1_idx = 0; bus.rs2_idx = 0;
    bus.rdata_a = 0; bus.csr_rdata = 0; bus.immed = 0; bus.zimmed = 0;
    bus.wb_ena = 0; bus.wb_idx = 0; bus.wb_wren = 0; bus.wb_pc = 0; bus.wb_data = 0;

    //            rden s1     s2     i1  i2  msw ra        csr       imm           z      e1        e2
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 6'd4, 6'd5, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 6'h00, 16'h1234, 16'h00F0};
    tbl[1]  = '{1'b1, 2'b00, 2'b00, 6'd1, 6'd0, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 6'h00, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b1, 2'b00, 2'b00, 6'd9, 6'd10,1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 6'h00, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 2'b01, 2'b01, 6'd0, 6'd0, 1'b0, 16'hCAFE, 16'h0000, 32'h89AB_CDEF, 6'h00, 16'hCAFE, 16'hCDEF};
    tbl[4]  = '{1'b1, 2'b01, 2'b01, 6'd0, 6'd0, 1'b1, 16'hCAFE, 16'h0000, 32'h89AB_CDEF, 6'h00, 16'hCAFE, 16'h89AB};
    tbl[5]  = '{1'b1, 2'b10, 2'b10, 6'd4, 6'd5, 1'b0, 16'h0000, 16'h0F0F, 32'h0000_0000, 6'h00, 16'h1F3F, 16'h0FFF};
    tbl[6]  = '{1'b1, 2'b11, 2'b11, 6'd0, 6'd0, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 6'h25, 16'h0005, 16'h0004};
    tbl[7]  = '{1'b1, 2'b11, 2'b11, 6'd0, 6'd0, 1'b1, 16'h0000, 16'h0000, 32'h0000_0000, 6'h25, 16'h8000, 16'h0000};
    tbl[8]  = '{1'b1, 2'b11, 2'b11, 6'd0, 6'd0, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 6'h3F, 16'h001F, 16'h0004};
    tbl[9]  = '{1'b1, 2'b01, 2'b10, 6'd0, 6'd4, 1'b1, 16'h5A5A, 16'h0F0F, 32'h0000_0000, 6'h00, 16'h5A5A, 16'h1F3F};
    tbl[10] = '{1'b0, 2'b00, 2'b00, 6'd4, 6'd5, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 6'h00, 16'h5A5A, 16'h1F3F};
    tbl[11] = '{1'b1, 2'b11, 2'b01, 6'd0, 6'd0, 1'b1, 16'h0000, 16'h0000, 32'h89AB_CDEF, 6'h1F, 16'h0000, 16'h89AB};

    // Reset state.
    step();
    step();
    check("reset_rdy", bus.rdy, 0);
    check("reset_rs1", bus.rs1_data, 0);
    check("reset_rs2", bus.rs2_data, 0);
    check("reset_bad_pc", bus.bad_pc, 0);

    // Clear sequence: rdy after 64 cycles, every slice reads zero.
    rst = 1'b1;
    wait_rdy("rdy_after_reset", 64);
    for (int i = 0; i < 64; i++) begin
      read_chk($sformatf("clr%0d", i), 6'(i), 6'(63 - i), 16'h0000, 16'h0000);
    end

    // Writes: normal, x0 (rejected), wb_ena=0 and wb_wren=0 (no effect).
    set_wb(6'd4, 16'h1234, 1'b0); step();
    step(); step();
    read_chk("wr_idx4", 6'd4, 6'd4, 16'h1234, 16'h1234);
    set_wb(6'd5, 16'h00F0, 1'b0); step();
    set_wb(6'd1, 16'hFFFF, 1'b0); step();
    set_wb(6'd0, 16'hFFFF, 1'b0); step();
    set_wb(6'd9, 16'h0001, 1'b0); bus.wb_ena = 1'b0; step();
    set_wb(6'd10, 16'h0001, 1'b0); bus.wb_wren = 1'b0; step();
    step(); step();

    // Operand mux vectors.
    for (int k = 0; k < 12; k++) begin
      bus.msw_sel   = tbl[k].msw;
      bus.rdata_a   = tbl[k].ra;
      bus.csr_rdata = tbl[k].csr;
      bus.immed     = tbl[k].imm;
      bus.zimmed    = tbl[k].z;
      bus.rs1_idx   = tbl[k].i1;
      bus.rs2_idx   = tbl[k].i2;
      bus.rs1_sel   = tbl[k].s1;
      bus.rs2_sel   = tbl[k].s2;
      bus.rs_rden   = tbl[k].rden;
      step();
      step();
      check($sformatf("vec%0d_rs1", k), bus.rs1_data, tbl[k].e1);
      check($sformatf("vec%0d_rs2", k), bus.rs2_data, tbl[k].e2);
    end
    bus.msw_sel = 0; bus.rdata_a = 0; bus.csr_rdata = 0; bus.immed = 0; bus.zimmed = 0;

    // Write in the p0 cycle of a read.
    set_wb(6'd6, 16'hBEEF, 1'b0);
    set_rd(6'd4, 6'd6, 2'b00, 2'b00);
    step(); step();
    check("byp_p0_rs1", bus.rs1_data, 16'h1234);
    check("byp_p0_rs2", bus.rs2_data, BYP ? 16'hBEEF : 16'h0000);
    read_chk("after_p0", 6'd6, 6'd6, 16'hBEEF, 16'hBEEF);

    // Write in the p1 cycle of a read.
    set_rd(6'd4, 6'd7, 2'b00, 2'b00);
    step();
    set_wb(6'd7, 16'h7777, 1'b0);
    step();
    check("byp_p1_rs2", bus.rs2_data, BYP ? 16'h7777 : 16'h0000);
    read_chk("after_p1", 6'd7, 6'd7, 16'h7777, 16'h7777);

    // Writes in both p0 and p1: the later one wins.
    set_wb(6'd8, 16'h1111, 1'b0);
    set_rd(6'd8, 6'd4, 2'b00, 2'b00);
    step();
    set_wb(6'd8, 16'h2222, 1'b0);
    step();
    check("byp_both_rs1", bus.rs1_data, BYP ? 16'h2222 : 16'h0000);

    // x0 is never forwarded.
    set_wb(6'd1, 16'hABCD, 1'b0);
    set_rd(6'd1, 6'd0, 2'b00, 2'b00);
    step(); step();
    check("byp_x0_rs1", bus.rs1_data, 16'h0000);

    // Forwarded PC LSW has bit 0 masked.
    set_wb(6'd12, 16'h0005, 1'b1);
    set_rd(6'd12, 6'd4, 2'b00, 2'b00);
    step(); step();
    check("byp_pc_rs1", bus.rs1_data, BYP ? 16'h0004 : 16'h0000);

    // PC fault: LSW with bit 1 set is suppressed, next write suppressed.
    set_wb(6'd2, 16'h0002, 1'b1); step();
    check("pc_fault_set", bus.bad_pc, 1);
    step();
    check("pc_fault_hold", bus.bad_pc, 1);
    set_wb(6'd3, 16'h8000, 1'b1); step();
    check("pc_fault_clr", bus.bad_pc, 0);
    read_chk("pc_suppressed", 6'd2, 6'd3, 16'h0000, 16'h0000);
    set_wb(6'd2, 16'h0005, 1'b1); step();
    check("pc_aligned_bad", bus.bad_pc, 0);
    read_chk("pc_aligned", 6'd2, 6'd3, 16'h0004, 16'h0000);

    // init_req restart: reads/writes ignored and outputs held in CLEAR.
    bus.init_req = 1'b1;
    step();
    check("init_rdy_low", bus.rdy, 0);
    repeat (9) step();
    set_wb(6'd4, 16'h5555, 1'b0);
    bus.rdata_a = 16'h9999;
    bus.immed   = 32'h1111_2222;
    set_rd(6'd4, 6'd5, 2'b01, 2'b01);
    step(); step(); step();
    check("clear_hold_rs1", bus.rs1_data, 16'h0004);
    check("clear_hold_rs2", bus.rs2_data, 16'h0000);
    wait_rdy("rdy_after_init", 52);
    bus.rdata_a = 0; bus.immed = 0;
    read_chk("reclr_4_5", 6'd4, 6'd5, 16'h0000, 16'h0000);
    read_chk("reclr_12_7", 6'd12, 6'd7, 16'h0000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
